// File: rtl/rx_buf_wr_ctrl.sv
// rtl/rx_buf_wr_ctrl.sv - RX sample buffer write controller with ping-pong host handoff
//
// Round-robin arbitrates NRX receiver channels, splits each 48-bit {I,Q}
// sample into three 16-bit BRAM words and fills one half of the buffer at a
// time. A full half is handed to the host (half_rdy) until host_ack returns it.
// Samples arriving while both halves belong to the host are granted, dropped
// and counted in ovfl_cnt (saturating).
//
// Optional feature macro: RXBUF_TICKS_EN - when defined, every half starts
// with a 3-word timestamp header (ticks latched on entry to HDR0, MSW first).
//
// Ports:
//   adc_clk, reset_n          clock, asynchronous active-low reset
//   enable                    capture enable
//   rx_req / rx_data / rx_gnt per-channel request, sample bus, one-hot grant
//   ticks                     free-running timestamp (header only)
//   buf_addra/dina/wea        registered BRAM write port
//   host_ack                  releases the oldest host-owned half
//   half_rdy, wr_half         host ownership per half, half being filled
//   ovfl_cnt                  dropped-sample counter
module rx_buf_wr_ctrl #(
    parameter int ADDR_MSB   = 12,
    parameter int NRX        = 4,
    parameter int NSAMP_HALF = 1360
) (
    input  logic                 adc_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NRX-1:0]       rx_req,
    input  logic [48*NRX-1:0]    rx_data,
    output logic [NRX-1:0]       rx_gnt,
    input  logic [47:0]          ticks,
    output logic [ADDR_MSB:0]    buf_addra,
    output logic [15:0]          buf_dina,
    output logic                 buf_wea,
    input  logic                 host_ack,
    output logic [1:0]           half_rdy,
    output logic                 wr_half,
    output logic [15:0]          ovfl_cnt
);

    localparam int GW = (NRX > 1) ? $clog2(NRX) : 1;
    localparam int CW = $clog2(NSAMP_HALF + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_ARB, S_W0, S_W1, S_W2, S_CLOSE, S_DROP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_MSB-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic                  rd_half_q, rd_half_d;
    logic                  wr_half_q, wr_half_d;
    logic [1:0]            half_rdy_q, half_rdy_d;
    logic [15:0]           ovfl_q, ovfl_d;
    logic [47:0]           sample_q, sample_d;
    logic [ADDR_MSB:0]     addr_q, addr_d;
    logic [15:0]           dina_q, dina_d;
    logic                  wea_q, wea_d;
`ifdef RXBUF_TICKS_EN
    logic [47:0]           ticks_q, ticks_d;
`else
    logic                  unused_ticks;
    assign unused_ticks = ^ticks;
`endif

    // Round-robin pick: lowest requester above last_grant, else lowest overall.
    logic          hi_found, lo_found, arb_found;
    logic [GW-1:0] hi_idx, lo_idx, arb_idx;
    logic [47:0]   arb_sample;

    always_comb begin
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        arb_sample = '0;
        for (int j = NRX - 1; j >= 0; j--) begin
            if (rx_req[j]) begin
                lo_found = 1'b1;
                lo_idx   = GW'(j);
                if (j > int'(last_grant_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(j);
                end
            end
        end
        arb_found = hi_found | lo_found;
        arb_idx   = hi_found ? hi_idx : lo_idx;
        for (int j = 0; j < NRX; j++) begin
            if (GW'(j) == arb_idx) begin
                arb_sample = rx_data[48*j +: 48];
            end
        end
    end

    logic grant_en;
    logic set_rdy;
    logic ack_ok;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rd_half_d    = rd_half_q;
        wr_half_d    = wr_half_q;
        half_rdy_d   = half_rdy_q;
        ovfl_d       = ovfl_q;
        sample_d     = sample_q;
        addr_d       = addr_q;
        dina_d       = dina_q;
        wea_d        = 1'b0;
        grant_en     = 1'b0;
        set_rdy      = 1'b0;
`ifdef RXBUF_TICKS_EN
        ticks_d      = ticks_q;
`endif

        // The write port is registered, so each write is set up on the
        // transition into the state in which it appears on buf_*.
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (half_rdy_q[wr_half_q]) begin
                        state_d = S_DROP;
                    end else begin
`ifdef RXBUF_TICKS_EN
                        state_d = S_HDR0;
                        ticks_d = ticks;
                        wea_d   = 1'b1;
                        addr_d  = {wr_half_q, ADDR_MSB'(0)};
                        dina_d  = ticks[47:32];
`else
                        state_d = S_ARB;
`endif
                    end
                end
            end
`ifdef RXBUF_TICKS_EN
            S_HDR0: begin
                state_d = S_HDR1;
                wea_d   = 1'b1;
                addr_d  = {wr_half_q, ADDR_MSB'(1)};
                dina_d  = ticks_q[31:16];
            end
            S_HDR1: begin
                state_d = S_HDR2;
                wea_d   = 1'b1;
                addr_d  = {wr_half_q, ADDR_MSB'(2)};
                dina_d  = ticks_q[15:0];
            end
            S_HDR2: begin
                state_d = S_ARB;
                ptr_d   = ADDR_MSB'(3);
            end
`endif
            S_ARB: begin
                if (arb_found) begin
                    grant_en     = 1'b1;
                    last_grant_d = arb_idx;
                    sample_d     = arb_sample;
                    state_d      = S_W0;
                    wea_d        = 1'b1;
                    addr_d       = {wr_half_q, ptr_q};
                    dina_d       = arb_sample[47:32];
                end else if (!enable) begin
                    // Idle while disabled: the partial half is abandoned.
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_W0: begin
                state_d = S_W1;
                wea_d   = 1'b1;
                addr_d  = {wr_half_q, ptr_q + ADDR_MSB'(1)};
                dina_d  = sample_q[23:8];
            end
            S_W1: begin
                state_d = S_W2;
                wea_d   = 1'b1;
                addr_d  = {wr_half_q, ptr_q + ADDR_MSB'(2)};
                dina_d  = {sample_q[31:24], sample_q[7:0]};
            end
            S_W2: begin
                ptr_d = ptr_q + ADDR_MSB'(3);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q + CW'(1) == CW'(NSAMP_HALF)) begin
                    // Handoff happens on entry to CLOSE so half_rdy is
                    // visible the cycle right after the last W2.
                    state_d   = S_CLOSE;
                    set_rdy   = 1'b1;
                    wr_half_d = ~wr_half_q;
                    ptr_d     = '0;
                    cnt_d     = '0;
                end else if (!enable) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_ARB;
                end
            end
            S_CLOSE: begin
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (!half_rdy_q[wr_half_q] || !enable) begin
                    state_d = S_IDLE;
                end else if (arb_found) begin
                    grant_en     = 1'b1;
                    last_grant_d = arb_idx;
                    if (ovfl_q != 16'hFFFF) begin
                        ovfl_d = ovfl_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set and ack never target the same half: a half is only closed
        // while the host does not own it.
        ack_ok = host_ack & half_rdy_q[rd_half_q];
        if (set_rdy) begin
            half_rdy_d[wr_half_q] = 1'b1;
        end
        if (ack_ok) begin
            half_rdy_d[rd_half_q] = 1'b0;
            rd_half_d             = ~rd_half_q;
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= GW'(NRX - 1);
            rd_half_q    <= 1'b0;
            wr_half_q    <= 1'b0;
            half_rdy_q   <= 2'b00;
            ovfl_q       <= 16'd0;
            sample_q     <= '0;
            addr_q       <= '0;
            dina_q       <= 16'd0;
            wea_q        <= 1'b0;
`ifdef RXBUF_TICKS_EN
            ticks_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rd_half_q    <= rd_half_d;
            wr_half_q    <= wr_half_d;
            half_rdy_q   <= half_rdy_d;
            ovfl_q       <= ovfl_d;
            sample_q     <= sample_d;
            addr_q       <= addr_d;
            dina_q       <= dina_d;
            wea_q        <= wea_d;
`ifdef RXBUF_TICKS_EN
            ticks_q      <= ticks_d;
`endif
        end
    end

    assign rx_gnt    = grant_en ? (NRX'(1) << arb_idx) : '0;
    assign buf_addra = addr_q;
    assign buf_dina  = dina_q;
    assign buf_wea   = wea_q;
    assign half_rdy  = half_rdy_q;
    assign wr_half   = wr_half_q;
    assign ovfl_cnt  = ovfl_q;

endmodule

// File: tb/tb_rx_buf_wr_ctrl.sv
// tb/tb_rx_buf_wr_ctrl.sv - scoreboard bench for rx_buf_wr_ctrl
module tb_rx_buf_wr_ctrl;

    localparam int AM = 4;
    localparam int NR = 4;
    localparam int NS = 4;
`ifdef RXBUF_TICKS_EN
    localparam int HW = 3;
`else
    localparam int HW = 0;
`endif
    localparam logic [47:0] TK = 48'h0123_4567_89AB;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic [NR-1:0]   rx_req;
    logic [48*NR-1:0] rx_data;
    logic [NR-1:0]   rx_gnt;
    logic [47:0]     ticks;
    logic [AM:0]     buf_addra;
    logic [15:0]     buf_dina;
    logic            buf_wea;
    logic            host_ack;
    logic [1:0]      half_rdy;
    logic            wr_half;
    logic [15:0]     ovfl_cnt;

    rx_buf_wr_ctrl #(.ADDR_MSB(AM), .NRX(NR), .NSAMP_HALF(NS)) dut (
        .adc_clk  (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rx_req   (rx_req),
        .rx_data  (rx_data),
        .rx_gnt   (rx_gnt),
        .ticks    (ticks),
        .buf_addra(buf_addra),
        .buf_dina (buf_dina),
        .buf_wea  (buf_wea),
        .host_ack (host_ack),
        .half_rdy (half_rdy),
        .wr_half  (wr_half),
        .ovfl_cnt (ovfl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AM:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec   = 0;
    int  n_bad   = 0;
    int  cyc     = 0;
    int  exp_gnt = 0;

    always @(posedge clk) cyc++;

    // Channel k: I = {0x12+k, 0x3456}, Q = {0xABCD, 0xEF-k}
    function automatic logic [47:0] samp(input int k);
        logic [23:0] i_v;
        logic [23:0] q_v;
        i_v = {8'h12 + 8'(k), 16'h3456};
        q_v = {16'hABCD, 8'hEF - 8'(k)};
        return {i_v, q_v};
    endfunction

    task automatic push_wr(input int a, input logic [15:0] d);
        wr_t e;
        e.a = (AM+1)'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sample(input int k, input int base);
        logic [47:0] s;
        s = samp(k);
        push_wr(base,     s[47:32]);
        push_wr(base + 1, s[23:8]);
        push_wr(base + 2, {s[31:24], s[7:0]});
    endtask

    task automatic push_hdr(input int base);
`ifdef RXBUF_TICKS_EN
        push_wr(base,     TK[47:32]);
        push_wr(base + 1, TK[31:16]);
        push_wr(base + 2, TK[15:0]);
`else
        if (base < 0) push_wr(base, 16'h0);
`endif
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic wait_wr(input int a, input int maxc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (buf_wea && buf_addra == (AM+1)'(a)) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_wr: no write to addr %0d within %0d cycles", a, maxc);
        end
    endtask

    task automatic wait_rdy(input logic [1:0] v, input int maxc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (half_rdy == v) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_rdy: half_rdy %b not reached, got %b", v, half_rdy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(rx_gnt),    32'd0);
        check({tag, "_addr"},  32'(buf_addra), 32'd0);
        check({tag, "_dina"},  32'(buf_dina),  32'd0);
        check({tag, "_wea"},   32'(buf_wea),   32'd0);
        check({tag, "_rdy"},   32'(half_rdy),  32'd0);
        check({tag, "_whalf"}, 32'(wr_half),   32'd0);
        check({tag, "_ovfl"},  32'(ovfl_cnt),  32'd0);
    endtask

    // Monitor: grants against a round-robin model (all requesters held
    // high whenever grants occur), writes against the scoreboard queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_gnt != '0) begin
                check("grant", 32'(rx_gnt), 32'(1) << exp_gnt);
                exp_gnt = (exp_gnt + 1) % NR;
            end
            if (buf_wea) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", buf_addra, buf_dina);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(buf_addra), 32'(e.a));
                    check("wr_data", 32'(buf_dina),  32'(e.d));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int t0;
        int k;
        logic [15:0] o0;
        logic [47:0] s;

        reset_n  = 1'b0;
        enable   = 1'b0;
        rx_req   = '0;
        host_ack = 1'b0;
        ticks    = TK;
        for (int c = 0; c < NR; c++) rx_data[48*c +: 48] = samp(c);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Fill both halves: grants 0,1,2,3 into each half.
        push_hdr(0);
        for (int i = 0; i < NS; i++) push_sample(i % NR, HW + 3*i);
        push_hdr(16);
        for (int i = 0; i < NS; i++) push_sample(i % NR, 16 + HW + 3*i);
        @(posedge clk); #1;
        enable = 1'b1;
        rx_req = '1;

        wait_wr(HW, 40);
        t0 = cyc;
        wait_wr(HW + 3, 40);
        check("sample_spacing", 32'(cyc - t0), 32'd4);
        wait_wr(HW + 11, 40);
        @(negedge clk);
        check("half0_rdy", 32'(half_rdy), 32'd1);
        check("half0_whalf", 32'(wr_half), 32'd1);

        wait_rdy(2'b11, 200);
        repeat (3) @(negedge clk);
        o0 = ovfl_cnt;
        repeat (10) @(negedge clk);
        check("drop_count", 32'(ovfl_cnt - o0), 32'd10);
        check("drop_no_writes", 32'(exp_q.size()), 32'd0);

        // Release half 0 and refill it.
        @(posedge clk); #1;
        rx_req = '0;
        @(posedge clk); #1;
        host_ack = 1'b1;
        @(posedge clk); #1;
        host_ack = 1'b0;
        @(negedge clk);
        check("ack0_rdy", 32'(half_rdy), 32'd2);
        push_hdr(0);
        for (int i = 0; i < NS; i++) push_sample((exp_gnt + i) % NR, HW + 3*i);
        rx_req = '1;
        wait_rdy(2'b11, 200);
        check("refill0_whalf", 32'(wr_half), 32'd1);

        // Overflow counter saturation.
        repeat (65540) @(negedge clk);
        check("ovfl_sat", 32'(ovfl_cnt), 32'hFFFF);
        repeat (5) @(negedge clk);
        check("ovfl_hold", 32'(ovfl_cnt), 32'hFFFF);

        // Release half 1, then disable during W1 of its first sample.
        @(posedge clk); #1;
        rx_req = '0;
        @(posedge clk); #1;
        host_ack = 1'b1;
        @(posedge clk); #1;
        host_ack = 1'b0;
        @(negedge clk);
        check("ack1_rdy", 32'(half_rdy), 32'd1);
        push_hdr(16);
        push_sample(exp_gnt, 16 + HW);
        rx_req = '1;
        wait_wr(16 + HW + 1, 40);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        check("dis_done", 32'(exp_q.size()), 32'd0);
        check("dis_rdy", 32'(half_rdy), 32'd1);
        check("dis_whalf", 32'(wr_half), 32'd1);

        // Re-enable: restart at ptr 0 of half 1; reset during W1 of 2nd sample.
        k = exp_gnt;
        push_hdr(16);
        push_sample(k, 16 + HW);
        s = samp((k + 1) % NR);
        push_wr(16 + HW + 3, s[47:32]);
        push_wr(16 + HW + 4, s[23:8]);
        enable = 1'b1;
        wait_wr(16 + HW + 4, 40);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("rst_pending", 32'(exp_q.size()), 32'd0);
        exp_gnt = 0;

        push_hdr(0);
        push_sample(0, HW);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_wr(0, 20);
        wait_wr(HW + 2, 20);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
